// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready request and response handshakes.
// Optional MULDIV_FAST_MUL_EN replaces the shift-add multiplier with a single-cycle product at accept.
module muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  localparam logic [2:0]      OP_MUL    = 3'd0;
  localparam logic [2:0]      OP_MULH   = 3'd1;
  localparam logic [2:0]      OP_MULHSU = 3'd2;
  localparam logic [2:0]      OP_DIV    = 3'd4;
  localparam logic [2:0]      OP_REM    = 3'd6;
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic                s1, s2, neg_res;
  logic                div0, ovf, mulz, early, go_done;
  logic [XLEN-1:0]     mag1, mag2, early_val;
  logic [XLEN:0]       div_sh, div_diff;

  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Sign fix-up and result selection once the magnitude iterations are complete.
  function automatic logic [XLEN-1:0] select_result(input logic [2:0] op, input logic neg,
                                                    input logic [2*XLEN-1:0] prod);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   v;
    if (!op[2]) begin
      p = neg ? -prod : prod;
      v = (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end else begin
      v = op[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      v = neg ? -v : v;
    end
    return v;
  endfunction

  assign accept = req_valid & req_ready & ~flush;

  // Operand preparation: signed operands become magnitudes, result sign kept separately.
  assign s1      = ((req_op == OP_MULH) || (req_op == OP_MULHSU) || (req_op == OP_DIV) ||
                    (req_op == OP_REM)) & req_op1[XLEN-1];
  assign s2      = ((req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM)) &
                   req_op2[XLEN-1];
  assign neg_res = (req_op[2] & req_op[1]) ? s1 : (s1 ^ s2);
  assign mag1    = abs_if(req_op1, s1);
  assign mag2    = abs_if(req_op2, s2);

  assign div0  = req_op[2] & (req_op2 == '0);
  assign ovf   = req_op[2] & ~req_op[0] & (req_op1 == MIN_NEG) & (req_op2 == '1);
  assign mulz  = ~req_op[2] & ((req_op1 == '0) | (req_op2 == '0));
  assign early = div0 | ovf | mulz;

  always_comb begin
    early_val = '0;
    if (div0)     early_val = req_op[1] ? req_op1 : '1;
    else if (ovf) early_val = req_op[1] ? '0 : MIN_NEG;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0]     fa, fb;
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_val;

  assign fa        = {s1 | (req_op == OP_MULH) & req_op1[XLEN-1] | (req_op == OP_MULHSU) & req_op1[XLEN-1], req_op1};
  assign fb        = {(req_op == OP_MULH) & req_op2[XLEN-1], req_op2};
  assign fast_prod = {{(XLEN-1){fa[XLEN]}}, fa} * {{(XLEN-1){fb[XLEN]}}, fb};
  assign fast_val  = (req_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  assign go_done   = early | ~req_op[2];
`else
  logic [XLEN:0]     mul_sum;
  assign go_done   = early;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = go_done ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Handshake outputs
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
  end

  assign resp_result = result_q;

  // Datapath: multiplier/divisor in a_q, product or {remainder, quotient} in prod_q.
  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    a_d      = a_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    div_sh   = '0;
    div_diff = '0;
`ifndef MULDIV_FAST_MUL_EN
    mul_sum  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = req_op;
          neg_d  = neg_res;
          a_d    = req_op[2] ? mag2 : mag1;
          prod_d = {{XLEN{1'b0}}, (req_op[2] ? mag1 : mag2)};
          cnt_d  = CNT_W'(XLEN);
          if (early) result_d = early_val;
`ifdef MULDIV_FAST_MUL_EN
          else if (!req_op[2]) result_d = fast_val;
`endif
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (op_q[2]) begin
            div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
            div_diff = div_sh - {1'b0, a_q};
            if (!div_diff[XLEN]) prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            else                 prod_d = {div_sh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
          end else begin
`ifndef MULDIV_FAST_MUL_EN
            mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
            prod_d  = {mul_sum, prod_q[XLEN-1:1]};
`endif
          end
        end else begin
          result_d = select_result(op_q, neg_q, prod_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results and latencies are queued at issue and
// compared when the response appears; also covers back-pressure, flush and mid-op reset.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_op = '0;
  logic [XLEN-1:0] req_op1 = '0;
  logic [XLEN-1:0] req_op2 = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference RV32M semantics.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, ua, ub, p;
    int     ia, ib;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    case (op)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            else return 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accept edge until resp_valid is seen high.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 0;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return XLEN + 1;
    end
    if (a == 0 || b == 0) return 0;
`ifdef MULDIV_FAST_MUL_EN
    return 0;
`else
    return XLEN + 1;
`endif
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int hold, input string tag);
    exp_t        e;
    int          cyc;
    logic [31:0] r0;
    sb_q.push_back('{res: exp_res, lat: exp_lat(op, a, b)});
    req_op    = op;
    req_op1   = a;
    req_op2   = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = sb_q.pop_front();
    check_eq({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    check_eq({tag, "_res"}, {32'b0, resp_result}, {32'b0, e.res});
    r0 = resp_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_res"}, {32'b0, resp_result}, {32'b0, r0});
      check_eq({tag, "_hold_rdy"}, {63'b0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq({tag, "_post_vld"}, {63'b0, resp_valid}, 64'd0);
    check_eq({tag, "_post_rdy"}, {63'b0, req_ready}, 64'd1);
  endtask

  initial begin
    int          seen;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [31:0] corner [6];

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {63'b0, req_ready}, 64'd1);
    check_eq("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check_eq("rst_resp_result", {32'b0, resp_result}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 0, "mulh_m1x2");
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 0, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 0, "remu_100_7");
    run_op(3'd5, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 0, "divu_by0");
    run_op(3'd6, 32'h1234_5678, 32'h0, 32'h1234_5678, 0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "rem_ovf");
    run_op(3'd0, 32'h0, 32'h1234_5678, 32'h0, 0, "mul_zero");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu_m1_max");

    // Back-pressure, then an immediate follow-on request.
    run_op(3'd5, 32'd1000, 32'd3, 32'd333, 5, "bp_divu");
    run_op(3'd0, 32'd6, 32'd7, 32'd42, 0, "bp_next_mul");

    // A request presented together with flush must not be taken.
    req_op = 3'd5; req_op1 = 32'd9; req_op2 = 32'd3;
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check_eq("flush_prio_rdy", {63'b0, req_ready}, 64'd1);
    check_eq("flush_prio_vld", {63'b0, resp_valid}, 64'd0);

    // Flush ten cycles into a divide.
    req_op = 3'd4; req_op1 = 32'd12345; req_op2 = 32'd17;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_vld", {63'b0, resp_valid}, 64'd0);
    check_eq("flush_rdy", {63'b0, req_ready}, 64'd1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen = 1; end
    check_eq("flush_no_resp", 64'(seen), 64'd0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_after_flush");

    // Asynchronous reset in the middle of an iterative op.
    req_op = 3'd5; req_op1 = 32'hDEAD_BEEF; req_op2 = 32'd13;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_req_ready", {63'b0, req_ready}, 64'd1);
    check_eq("arst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check_eq("arst_resp_result", {32'b0, resp_result}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen = 1; end
    check_eq("arst_no_resp", 64'(seen), 64'd0);
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 0, "mul_after_rst");

    // Random operations mixed with corner operands.
    corner[0] = 32'h0;         corner[1] = 32'h1;         corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h0000_0003;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      run_op(rop, ra, rb, model(rop, ra, rb), 0, $sformatf("rnd%0d_op%0d", i, rop));
    end

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
